// File: rtl/alu_issue_stage_if.sv
// ID/EX issue bus: fetched instruction with operands in, decoded Alu controls out.
// Stall/flush travel on the same bundle as the instruction they qualify.
interface alu_issue_stage_if;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic        ex_valid;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [5:0]  ex_ALUFun;
  logic        ex_Sign;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic        ex_illegal;

  modport master (
    output stall, flush, in_valid, instr, rs_data, rt_data,
    input  ex_valid, ex_A, ex_B, ex_ALUFun, ex_Sign, ex_rd,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_illegal
  );

  modport slave (
    input  stall, flush, in_valid, instr, rs_data, rt_data,
    output ex_valid, ex_A, ex_B, ex_ALUFun, ex_Sign, ex_rd,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decodes one MIPS instruction into Alu controls/operands and registers them at ID/EX.
// Latency 1 cycle; stall holds the slot, flush (over stall) or in_valid=0 loads a bubble.
module alu_issue_stage (
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus
);

  localparam logic [5:0] FUN_ADD  = 6'b000000;
  localparam logic [5:0] FUN_SUB  = 6'b000001;
  localparam logic [5:0] FUN_AND  = 6'b011000;
  localparam logic [5:0] FUN_OR   = 6'b011110;
  localparam logic [5:0] FUN_XOR  = 6'b010110;
  localparam logic [5:0] FUN_NOR  = 6'b010001;
  localparam logic [5:0] FUN_PASA = 6'b011010;
  localparam logic [5:0] FUN_SLL  = 6'b100000;
  localparam logic [5:0] FUN_SRL  = 6'b100001;
  localparam logic [5:0] FUN_SRA  = 6'b100011;
  localparam logic [5:0] FUN_EQ   = 6'b110011;
  localparam logic [5:0] FUN_NEQ  = 6'b110001;
  localparam logic [5:0] FUN_LT   = 6'b110101;
  localparam logic [5:0] FUN_LEZ  = 6'b111101;
  localparam logic [5:0] FUN_LTZ  = 6'b111011;
  localparam logic [5:0] FUN_GTZ  = 6'b111111;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } ex_t;

  ex_t         w_dec;
  ex_t         r_ex;
  logic        w_legal;
  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rt_f;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_shamt;
  logic        w_unused;

  assign w_op     = bus.instr[31:26];
  assign w_fn     = bus.instr[5:0];
  assign w_rt_f   = bus.instr[20:16];
  assign w_sext   = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign w_zext   = {16'b0, bus.instr[15:0]};
  assign w_shamt  = {27'b0, bus.instr[10:6]};
  // The rs field only selects the register file read; rs_data already carries its value.
  assign w_unused = ^bus.instr[25:21];

  always_comb begin
    // I-type layout is the default; R-type and branches override what differs.
    w_dec           = '0;
    w_legal         = 1'b1;
    w_dec.valid     = 1'b1;
    w_dec.a         = bus.rs_data;
    w_dec.b         = w_sext;
    w_dec.rd        = w_rt_f;
    w_dec.reg_write = 1'b1;
    case (w_op)
      6'h00: begin
        w_dec.b  = bus.rt_data;
        w_dec.rd = bus.instr[15:11];
        case (w_fn)
          6'h20: begin w_dec.fun = FUN_ADD; w_dec.sign = 1'b1; end
          6'h21: w_dec.fun = FUN_ADD;
          6'h22: begin w_dec.fun = FUN_SUB; w_dec.sign = 1'b1; end
          6'h23: w_dec.fun = FUN_SUB;
          6'h24: w_dec.fun = FUN_AND;
          6'h25: w_dec.fun = FUN_OR;
          6'h26: w_dec.fun = FUN_XOR;
          6'h27: w_dec.fun = FUN_NOR;
          6'h2A: begin w_dec.fun = FUN_LT; w_dec.sign = 1'b1; end
          6'h2B: w_dec.fun = FUN_LT;
          6'h00: begin w_dec.fun = FUN_SLL; w_dec.a = w_shamt; end
          6'h02: begin w_dec.fun = FUN_SRL; w_dec.a = w_shamt; end
          6'h03: begin w_dec.fun = FUN_SRA; w_dec.a = w_shamt; end
          6'h04: w_dec.fun = FUN_SLL;
          6'h06: w_dec.fun = FUN_SRL;
          6'h07: w_dec.fun = FUN_SRA;
          6'h08: begin
            w_dec.fun       = FUN_ADD;
            w_dec.a         = '0;
            w_dec.b         = '0;
            w_dec.reg_write = 1'b0;
          end
          default: w_legal = 1'b0;
        endcase
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        w_dec.b         = bus.rt_data;
        w_dec.rd        = '0;
        w_dec.reg_write = 1'b0;
        w_dec.sign      = 1'b1;
        case (w_op)
          6'h04:   w_dec.fun = FUN_EQ;
          6'h05:   w_dec.fun = FUN_NEQ;
          6'h06:   w_dec.fun = FUN_LEZ;
          6'h07:   w_dec.fun = FUN_GTZ;
          default: begin
            w_dec.fun = FUN_LTZ;
            w_legal   = (w_rt_f == 5'd0);
          end
        endcase
      end
      6'h08: begin w_dec.fun = FUN_ADD; w_dec.sign = 1'b1; end
      6'h09: w_dec.fun = FUN_ADD;
      6'h0A: begin w_dec.fun = FUN_LT; w_dec.sign = 1'b1; end
      6'h0B: w_dec.fun = FUN_LT;
      6'h0C: begin w_dec.fun = FUN_AND; w_dec.b = w_zext; end
      6'h0D: begin w_dec.fun = FUN_OR; w_dec.b = w_zext; end
      6'h0F: begin
        w_dec.fun = FUN_PASA;
        w_dec.a   = {bus.instr[15:0], 16'b0};
        w_dec.b   = '0;
      end
      6'h23: begin w_dec.fun = FUN_ADD; w_dec.mem_read = 1'b1; end
      6'h2B: begin
        w_dec.fun       = FUN_ADD;
        w_dec.mem_write = 1'b1;
        w_dec.reg_write = 1'b0;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.valid   = 1'b1;
      w_dec.illegal = 1'b1;
    end
    if (w_dec.rd == 5'd0) w_dec.reg_write = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_ex <= '0;
    end else if (!bus.stall) begin
      r_ex <= bus.in_valid ? w_dec : '0;
    end
  end

  assign bus.ex_valid    = r_ex.valid;
  assign bus.ex_A        = r_ex.a;
  assign bus.ex_B        = r_ex.b;
  assign bus.ex_ALUFun   = r_ex.fun;
  assign bus.ex_Sign     = r_ex.sign;
  assign bus.ex_rd       = r_ex.rd;
  assign bus.ex_RegWrite = r_ex.reg_write;
  assign bus.ex_MemRead  = r_ex.mem_read;
  assign bus.ex_MemWrite = r_ex.mem_write;
  assign bus.ex_illegal  = r_ex.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed test-plan steps followed by randomized instructions/controls against a mnemonic-level model.
module tb_alu_issue_stage;

  logic clk;
  logic reset;
  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR,
    M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_LUI, M_LW, M_SW,
    M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_ILL
  } mn_t;

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
    bit          sign_care;
    bit          rd_care;
  } exp_t;

  localparam logic [5:0] RF [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                     6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] IO [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F,
                                     6'h23, 6'h2B, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01};

  int   n_vec;
  int   n_err;
  exp_t exp_cur;

  function automatic mn_t mnem(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return M_ADD;   6'h21: return M_ADDU;
        6'h22: return M_SUB;   6'h23: return M_SUBU;
        6'h24: return M_AND;   6'h25: return M_OR;
        6'h26: return M_XOR;   6'h27: return M_NOR;
        6'h2A: return M_SLT;   6'h2B: return M_SLTU;
        6'h00: return M_SLL;   6'h02: return M_SRL;
        6'h03: return M_SRA;   6'h04: return M_SLLV;
        6'h06: return M_SRLV;  6'h07: return M_SRAV;
        6'h08: return M_JR;
        default: return M_ILL;
      endcase
    end
    case (op)
      6'h01: return (ins[20:16] == 5'd0) ? M_BLTZ : M_ILL;
      6'h04: return M_BEQ;   6'h05: return M_BNE;
      6'h06: return M_BLEZ;  6'h07: return M_BGTZ;
      6'h08: return M_ADDI;  6'h09: return M_ADDIU;
      6'h0A: return M_SLTI;  6'h0B: return M_SLTIU;
      6'h0C: return M_ANDI;  6'h0D: return M_ORI;
      6'h0F: return M_LUI;   6'h23: return M_LW;
      6'h2B: return M_SW;
      default: return M_ILL;
    endcase
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{valid: 1'b0, a: '0, b: '0, fun: '0, sign: 1'b0, rd: '0, rw: 1'b0,
          mr: 1'b0, mw: 1'b0, ill: 1'b0, sign_care: 1'b1, rd_care: 1'b1};
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    mn_t         m;
    logic [31:0] sx;
    logic [31:0] zx;
    m  = mnem(ins);
    sx = 32'(signed'(ins[15:0]));
    zx = 32'(ins[15:0]);
    e  = bubble();
    e.valid = 1'b1;
    if (m == M_ILL) begin
      e.ill = 1'b1;
      e.sign_care = 1'b0;
      e.rd_care = 1'b0;
      return e;
    end
    e.a = rs;
    if (ins[31:26] == 6'h00) begin
      e.b = rt; e.rd = ins[15:11]; e.rw = 1'b1;
    end else if (m inside {M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ}) begin
      e.b = rt; e.rw = 1'b0; e.sign = 1'b1; e.rd_care = 1'b0;
    end else begin
      e.b = sx; e.rd = ins[20:16]; e.rw = 1'b1;
    end
    case (m)
      M_ADD:   begin e.fun = 6'b000000; e.sign = 1'b1; end
      M_ADDU:  e.fun = 6'b000000;
      M_SUB:   begin e.fun = 6'b000001; e.sign = 1'b1; end
      M_SUBU:  e.fun = 6'b000001;
      M_AND:   e.fun = 6'b011000;
      M_OR:    e.fun = 6'b011110;
      M_XOR:   e.fun = 6'b010110;
      M_NOR:   e.fun = 6'b010001;
      M_SLT:   begin e.fun = 6'b110101; e.sign = 1'b1; end
      M_SLTU:  e.fun = 6'b110101;
      M_SLL:   begin e.fun = 6'b100000; e.a = 32'(ins[10:6]); e.sign_care = 1'b0; end
      M_SRL:   begin e.fun = 6'b100001; e.a = 32'(ins[10:6]); e.sign_care = 1'b0; end
      M_SRA:   begin e.fun = 6'b100011; e.a = 32'(ins[10:6]); e.sign_care = 1'b0; end
      M_SLLV:  begin e.fun = 6'b100000; e.sign_care = 1'b0; end
      M_SRLV:  begin e.fun = 6'b100001; e.sign_care = 1'b0; end
      M_SRAV:  begin e.fun = 6'b100011; e.sign_care = 1'b0; end
      M_JR:    begin e.fun = 6'b000000; e.a = 0; e.b = 0; e.rw = 1'b0; e.sign_care = 1'b0; end
      M_ADDI:  begin e.fun = 6'b000000; e.sign = 1'b1; end
      M_ADDIU: e.fun = 6'b000000;
      M_SLTI:  begin e.fun = 6'b110101; e.sign = 1'b1; end
      M_SLTIU: e.fun = 6'b110101;
      M_ANDI:  begin e.fun = 6'b011000; e.b = zx; e.sign_care = 1'b0; end
      M_ORI:   begin e.fun = 6'b011110; e.b = zx; e.sign_care = 1'b0; end
      M_LUI:   begin e.fun = 6'b011010; e.a = {ins[15:0], 16'h0000}; e.b = 0; e.sign_care = 1'b0; end
      M_LW:    begin e.fun = 6'b000000; e.mr = 1'b1; end
      M_SW:    begin e.fun = 6'b000000; e.mw = 1'b1; e.rw = 1'b0; end
      M_BEQ:   e.fun = 6'b110011;
      M_BNE:   e.fun = 6'b110001;
      M_BLEZ:  e.fun = 6'b111101;
      M_BGTZ:  e.fun = 6'b111111;
      M_BLTZ:  e.fun = 6'b111011;
      default: e.ill = 1'b1;
    endcase
    if (e.rd_care && e.rd == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    k   = $urandom_range(0, 33);
    if (k < 17) begin
      ins[31:26] = 6'h00;
      ins[5:0]   = RF[k];
    end else if (k < 31) begin
      ins[31:26] = IO[k-17];
      if (IO[k-17] == 6'h01 && $urandom_range(0, 1) == 1) ins[20:16] = 5'd0;
    end
    return ins;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"},  32'(bus.ex_valid),    32'(exp_cur.valid));
    check({tag, ".A"},      bus.ex_A,             exp_cur.a);
    check({tag, ".B"},      bus.ex_B,             exp_cur.b);
    check({tag, ".ALUFun"}, 32'(bus.ex_ALUFun),   32'(exp_cur.fun));
    check({tag, ".RegWr"},  32'(bus.ex_RegWrite), 32'(exp_cur.rw));
    check({tag, ".MemRd"},  32'(bus.ex_MemRead),  32'(exp_cur.mr));
    check({tag, ".MemWr"},  32'(bus.ex_MemWrite), 32'(exp_cur.mw));
    check({tag, ".illegal"},32'(bus.ex_illegal),  32'(exp_cur.ill));
    if (exp_cur.sign_care) check({tag, ".Sign"}, 32'(bus.ex_Sign), 32'(exp_cur.sign));
    if (exp_cur.rd_care)   check({tag, ".rd"},   32'(bus.ex_rd),   32'(exp_cur.rd));
  endtask

  // One clock edge: drive at negedge, advance the model by the edge priority, sample after the edge.
  task automatic step(input string tag, input logic rst, input logic fl, input logic st,
                      input logic v, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt);
    @(negedge clk);
    reset        = rst;
    bus.flush    = fl;
    bus.stall    = st;
    bus.in_valid = v;
    bus.instr    = ins;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    if (rst || fl)  exp_cur = bubble();
    else if (!st)   exp_cur = v ? model(ins, rs, rt) : bubble();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_cur = bubble();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.rs_data = '0;
    bus.rt_data = '0;

    step("reset0", 1, 0, 0, 1, 32'h00221820, 32'd5, 32'd7);
    step("reset1", 1, 0, 0, 1, 32'h00221820, 32'd5, 32'd7);
    check("reset_valid_const", 32'(bus.ex_valid), 32'd0);

    step("add", 0, 0, 0, 1, 32'h00221820, 32'd5, 32'd7);
    check("add_A_const",  bus.ex_A, 32'd5);
    check("add_rd_const", 32'(bus.ex_rd), 32'd3);

    step("sra", 0, 0, 0, 1, 32'h000520C3, 32'h1111_2222, 32'h8000_0000);
    check("sra_fun_const", 32'(bus.ex_ALUFun), 32'b100011);
    check("sra_A_const",   bus.ex_A, 32'd3);

    step("lui", 0, 0, 0, 1, 32'h3C011234, 32'hDEAD_BEEF, 32'h0);
    check("lui_A_const", bus.ex_A, 32'h1234_0000);

    step("addiu", 0, 0, 0, 1, 32'h2402FFFF, 32'h0, 32'h0);
    check("addiu_B_const", bus.ex_B, 32'hFFFF_FFFF);
    step("andi", 0, 0, 0, 1, 32'h3002FFFF, 32'h0, 32'h0);
    check("andi_B_const", bus.ex_B, 32'h0000_FFFF);

    step("beq", 0, 0, 0, 1, 32'h10220004, 32'd9, 32'd9);
    for (int i = 0; i < 3; i++) step("stall_hold", 0, 0, 1, 1, rand_instr(), $urandom, $urandom);
    check("stall_fun_const", 32'(bus.ex_ALUFun), 32'b110011);
    step("stall_flush", 0, 1, 1, 1, 32'h00221820, 32'd1, 32'd2);

    step("illegal", 0, 0, 0, 1, 32'hFC000000, 32'h1234, 32'h5678);
    check("illegal_const", 32'(bus.ex_illegal), 32'd1);
    step("addu_rd0", 0, 0, 0, 1, 32'h00220021, 32'd1, 32'd2);
    check("addu_rd0_rw_const", 32'(bus.ex_RegWrite), 32'd0);
    step("no_valid", 0, 0, 0, 0, 32'h00221820, 32'd1, 32'd2);
    step("sw", 0, 0, 0, 1, 32'hAC22FFFC, 32'h100, 32'h5);
    step("flush_only", 0, 1, 0, 1, 32'h8C22_0010, 32'h100, 32'h5);

    for (int i = 0; i < 600; i++) begin
      logic rs_b, fl_b, st_b, v_b;
      rs_b = ($urandom_range(0, 99) < 2);
      fl_b = ($urandom_range(0, 99) < 8);
      st_b = ($urandom_range(0, 99) < 20);
      v_b  = ($urandom_range(0, 99) < 85);
      step($sformatf("rand%0d", i), rs_b, fl_b, st_b, v_b, rand_instr(), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
